program_ram: RTL and testbench

- 16x8 program/data RAM for the SAP-style CPU.
- Takes the address held by the memory address register and drives the addressed byte onto the W bus when ce_n is low (run mode).
- In program mode, a loader FSM fills memory sequentially from address 0 over a valid/ready byte stream, with an auto-incrementing write pointer and a completion flag.

---
 rtl/program_ram.sv | 142 ++++++++++++++
 tb/tb_program_ram.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/program_ram.sv
`default_nettype none
// ============================================================================
// Module   : program_ram
// Purpose  : 16x8 program/data RAM for a SAP-style CPU. In run mode the word
//            addressed by the memory address register is driven toward the W
//            bus with zero latency. In program mode a loader fills memory
//            sequentially from address 0 over a valid/ready byte stream.
// Ports    : clk, rst           - clock, synchronous active-high reset
//            ram_addres, ce_n   - run-mode read address / active-low enable
//            prog_mode          - 1 = loader active, 0 = run mode
//            prog_valid/_data   - loader byte stream input
//            prog_ready         - loader can accept a byte this cycle
//            prog_done          - all words written since entering prog mode
//            prog_addr          - current loader write pointer
//            w_bus_out/_oe      - data and drive enable toward the W bus
// Revision : 1.0 - initial release
// ============================================================================
module program_ram #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] ram_addres,
    input  logic              ce_n,
    input  logic              prog_mode,
    input  logic              prog_valid,
    input  logic [DATA_W-1:0] prog_data,
    output logic              prog_ready,
    output logic              prog_done,
    output logic [ADDR_W-1:0] prog_addr,
    output logic [DATA_W-1:0] w_bus_out,
    output logic              w_bus_oe
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] c_LAST_ADDR = '1;
    localparam logic [ADDR_W-1:0] c_ONE       = {{(ADDR_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic              w_wr_en;
    logic              w_start;
    logic              w_oe;
    logic [ADDR_W-1:0] r_prog_addr;
    logic [DATA_W-1:0] r_mem [DEPTH];

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and loader handshake decode
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        w_wr_en      = 1'b0;
        w_start      = 1'b0;
        prog_ready   = 1'b0;
        prog_done    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (prog_mode) begin
                    w_next_state = S_LOAD;
                    w_start      = 1'b1;
                end
            end
            S_LOAD: begin
                prog_ready = 1'b1;
                // Leaving program mode wins over a pending byte: the abort
                // edge must never write.
                if (!prog_mode) begin
                    w_next_state = S_IDLE;
                end else if (prog_valid) begin
                    w_wr_en = 1'b1;
                    if (r_prog_addr == c_LAST_ADDR) begin
                        w_next_state = S_DONE;
                    end
                end
            end
            S_DONE: begin
                prog_done = 1'b1;
                if (!prog_mode) begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Write pointer: restarts at 0 on every entry to LOAD; the increment
    // after the last word wraps to 0 by modulo arithmetic.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_prog_addr <= '0;
        end else if (w_start) begin
            r_prog_addr <= '0;
        end else if (w_wr_en) begin
            r_prog_addr <= r_prog_addr + c_ONE;
        end
    end

    // ------------------------------------------------------------------
    // Memory array: cleared on reset, written only at the loader pointer
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_mem[r_prog_addr] <= prog_data;
        end
    end

    // ------------------------------------------------------------------
    // Combinational read path; the bus is never driven in program mode
    // ------------------------------------------------------------------
    assign w_oe      = ~ce_n & ~prog_mode;
    assign w_bus_oe  = w_oe;
    assign w_bus_out = w_oe ? r_mem[ram_addres] : '0;
    assign prog_addr = r_prog_addr;

endmodule
`default_nettype wire

// File: tb/tb_program_ram.sv
`default_nettype none
// ============================================================================
// Module   : tb_program_ram
// Purpose  : Self-checking bench for program_ram: vector table, directed
//            multi-cycle sequences and randomized traffic against a model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_program_ram;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] ram_addres;
    logic       ce_n;
    logic       prog_mode;
    logic       prog_valid;
    logic [7:0] prog_data;
    logic       prog_ready;
    logic       prog_done;
    logic [3:0] prog_addr;
    logic [7:0] w_bus_out;
    logic       w_bus_oe;

    int n_tests = 0;
    int n_fail  = 0;

    program_ram #(.ADDR_W(4), .DATA_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .ram_addres (ram_addres),
        .ce_n       (ce_n),
        .prog_mode  (prog_mode),
        .prog_valid (prog_valid),
        .prog_data  (prog_data),
        .prog_ready (prog_ready),
        .prog_done  (prog_done),
        .prog_addr  (prog_addr),
        .w_bus_out  (w_bus_out),
        .w_bus_oe   (w_bus_oe)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model: phase 0 = idle, 1 = loading, 2 = load complete
    // ------------------------------------------------------------------
    logic [7:0] m_mem [16];
    int         m_phase;
    int         m_ptr;

    task automatic model_edge();
        if (rst) begin
            m_phase = 0;
            m_ptr   = 0;
            for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
        end else if (m_phase == 0) begin
            if (prog_mode) begin
                m_phase = 1;
                m_ptr   = 0;
            end
        end else if (m_phase == 1) begin
            if (!prog_mode) begin
                m_phase = 0;
            end else if (prog_valid) begin
                m_mem[m_ptr] = prog_data;
                m_ptr        = (m_ptr + 1) % 16;
                if (m_ptr == 0) m_phase = 2;
            end
        end else begin
            if (!prog_mode) m_phase = 0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_model(input string tag);
        logic       e_oe;
        logic [7:0] e_out;
        e_oe  = !ce_n && !prog_mode;
        e_out = e_oe ? m_mem[ram_addres] : 8'h00;
        chk({tag, ".ready"}, {31'd0, prog_ready}, {31'd0, m_phase == 1});
        chk({tag, ".done"},  {31'd0, prog_done},  {31'd0, m_phase == 2});
        chk({tag, ".addr"},  {28'd0, prog_addr},  m_ptr);
        chk({tag, ".oe"},    {31'd0, w_bus_oe},   {31'd0, e_oe});
        chk({tag, ".out"},   {24'd0, w_bus_out},  {24'd0, e_out});
    endtask

    task automatic drive(input logic r, input logic pm, input logic v,
                         input logic [7:0] d, input logic c, input logic [3:0] a);
        rst = r; prog_mode = pm; prog_valid = v; prog_data = d; ce_n = c; ram_addres = a;
    endtask

    // ------------------------------------------------------------------
    // Vector table: inputs applied, outputs checked, then one clock edge
    // ------------------------------------------------------------------
    typedef struct packed {
        logic       pm;
        logic       v;
        logic [7:0] d;
        logic       ce;
        logic [3:0] a;
        logic       rdy;
        logic       dn;
        logic [3:0] pa;
        logic       oe;
        logic [7:0] out;
    } vec_t;

    function automatic vec_t mk(input logic pm, input logic v, input logic [7:0] d,
                                input logic ce, input logic [3:0] a, input logic rdy,
                                input logic dn, input logic [3:0] pa, input logic oe,
                                input logic [7:0] out);
        vec_t t;
        t.pm = pm; t.v = v; t.d = d; t.ce = ce; t.a = a;
        t.rdy = rdy; t.dn = dn; t.pa = pa; t.oe = oe; t.out = out;
        return t;
    endfunction

    vec_t tbl [16];

    initial begin
        //            pm  v   d      ce  a     rdy dn  pa    oe  out
        tbl[0]  = mk(0,  0,  8'h00, 0,  4'd5, 0,  0,  4'd0, 1,  8'h00); // after reset
        tbl[1]  = mk(1,  0,  8'h00, 0,  4'd5, 0,  0,  4'd0, 0,  8'h00); // enter prog mode
        tbl[2]  = mk(1,  1,  8'hA0, 0,  4'd0, 1,  0,  4'd0, 0,  8'h00);
        tbl[3]  = mk(1,  0,  8'hA1, 0,  4'd0, 1,  0,  4'd1, 0,  8'h00);
        tbl[4]  = mk(1,  1,  8'hA1, 0,  4'd0, 1,  0,  4'd1, 0,  8'h00);
        tbl[5]  = mk(1,  0,  8'hA2, 0,  4'd0, 1,  0,  4'd2, 0,  8'h00);
        tbl[6]  = mk(1,  1,  8'hA2, 0,  4'd0, 1,  0,  4'd2, 0,  8'h00);
        tbl[7]  = mk(1,  0,  8'hA3, 0,  4'd0, 1,  0,  4'd3, 0,  8'h00);
        tbl[8]  = mk(1,  1,  8'hA3, 0,  4'd0, 1,  0,  4'd3, 0,  8'h00);
        tbl[9]  = mk(1,  0,  8'hA3, 0,  4'd0, 1,  0,  4'd4, 0,  8'h00);
        tbl[10] = mk(0,  1,  8'h77, 0,  4'd0, 1,  0,  4'd4, 1,  8'hA0); // abort edge
        tbl[11] = mk(0,  0,  8'h00, 0,  4'd3, 0,  0,  4'd4, 1,  8'hA3);
        tbl[12] = mk(0,  0,  8'h00, 0,  4'd4, 0,  0,  4'd4, 1,  8'h00); // 0x77 not written
        tbl[13] = mk(0,  0,  8'h00, 1,  4'd1, 0,  0,  4'd4, 0,  8'h00); // ce_n high
        tbl[14] = mk(1,  0,  8'h00, 0,  4'd1, 0,  0,  4'd4, 0,  8'h00); // re-enter
        tbl[15] = mk(1,  0,  8'h00, 0,  4'd1, 1,  0,  4'd0, 0,  8'h00); // restarted at 0

        drive(1, 0, 0, 8'h00, 1, 4'd0);
        tick();
        tick();

        for (int i = 0; i < 16; i++) begin
            drive(0, tbl[i].pm, tbl[i].v, tbl[i].d, tbl[i].ce, tbl[i].a);
            #1;
            chk($sformatf("vec%0d.ready", i), {31'd0, prog_ready}, {31'd0, tbl[i].rdy});
            chk($sformatf("vec%0d.done", i),  {31'd0, prog_done},  {31'd0, tbl[i].dn});
            chk($sformatf("vec%0d.addr", i),  {28'd0, prog_addr},  {28'd0, tbl[i].pa});
            chk($sformatf("vec%0d.oe", i),    {31'd0, w_bus_oe},   {31'd0, tbl[i].oe});
            chk($sformatf("vec%0d.out", i),   {24'd0, w_bus_out},  {24'd0, tbl[i].out});
            tick();
        end

        // Full load of 16 back-to-back bytes, then extra bytes while done
        drive(0, 0, 0, 8'h00, 0, 4'd0);
        tick();
        drive(0, 1, 0, 8'h00, 0, 4'd0);
        tick();
        for (int i = 0; i < 16; i++) begin
            drive(0, 1, 1, 8'(8'h10 + i), 0, 4'(i));
            #1;
            chk($sformatf("full%0d.ready", i), {31'd0, prog_ready}, 32'd1);
            chk($sformatf("full%0d.addr", i),  {28'd0, prog_addr},  i);
            chk($sformatf("full%0d.oe", i),    {30'd0, w_bus_oe, |w_bus_out}, 32'd0);
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 1, 8'hEE, 0, 4'd0);
            #1;
            chk($sformatf("done%0d.flags", i), {30'd0, prog_done, prog_ready}, 32'd2);
            chk($sformatf("done%0d.addr", i),  {28'd0, prog_addr}, 32'd0);
            tick();
        end
        for (int a = 0; a < 16; a++) begin
            drive(0, 0, 1, 8'hEE, 0, 4'(a));
            #1;
            chk($sformatf("sweep%0d", a), {23'd0, w_bus_oe, w_bus_out}, 32'h100 + 32'h10 + a);
            tick();
        end

        // Reset in the middle of a load
        drive(0, 1, 0, 8'h00, 0, 4'd0);
        tick();
        for (int i = 0; i < 7; i++) begin
            drive(0, 1, 1, 8'(8'h30 + i), 0, 4'd0);
            tick();
        end
        drive(1, 1, 1, 8'h99, 0, 4'd0);
        tick();
        drive(0, 0, 0, 8'h00, 0, 4'd0);
        #1;
        chk("rstmid.flags", {30'd0, prog_done, prog_ready}, 32'd0);
        chk("rstmid.addr",  {28'd0, prog_addr}, 32'd0);
        for (int a = 0; a < 16; a++) begin
            drive(0, 0, 0, 8'h00, 0, 4'(a));
            #1;
            chk($sformatf("rstmid.rd%0d", a), {24'd0, w_bus_out}, 32'd0);
            tick();
        end

        // Randomized traffic against the reference model
        prog_mode = 1'b0;
        for (int n = 0; n < 800; n++) begin
            logic pm_next;
            pm_next = ($urandom_range(0, 24) == 0) ? !prog_mode : prog_mode;
            drive(($urandom_range(0, 79) == 0), pm_next, ($urandom_range(0, 3) != 0),
                  8'($urandom), ($urandom_range(0, 2) == 0), 4'($urandom));
            #1;
            chk_model($sformatf("rnd%0d", n));
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
